fir_comp_scheduler: RTL and testbench

FIR_COMP_SCHEDULER -- requirements
Module: fir_comp_scheduler

---
 rtl/fir_sched_pkg.sv | 16 +
 rtl/fir_sched_rr_arb.sv | 31 +++
 rtl/fir_comp_scheduler.sv | 139 +++++++++++++
 tb/tb_fir_comp_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared definitions for the FIR compensation scheduler: FSM encoding,
// default geometry and the statistics counter width.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DATA_W   = 12;
  localparam int DEF_PIPE_LAT = 3;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/fir_sched_rr_arb.sv
// Round-robin picker: first eligible channel searching upward from ptr,
// wrapping at NUM_CH. Purely combinational.
module fir_sched_rr_arb #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  // Scan NUM_CH positions starting at ptr; the first hit wins.
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!gnt_vld && elig[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_comp_scheduler.sv
// Time-shares one fixed-latency compensation datapath between NUM_CH FIR
// channels. Issues are tracked by a tag shift register (no datapath valid
// is used) and results land in one holding slot per channel.
// Optional: define FIR_SCHED_STATS_EN to add per-channel saturating grant
// counters on stat_grant_cnt.
module fir_comp_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     dp_valid,
  output logic [DATA_W-1:0]        dp_data,
  input  logic [DATA_W-1:0]        dp_result,
  output logic [NUM_CH-1:0]        res_valid,
  output logic [NUM_CH*DATA_W-1:0] res_data,
  input  logic [NUM_CH-1:0]        res_ready,
  output logic                     busy
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [NUM_CH*STAT_W-1:0] stat_grant_cnt
`endif
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t                          state, state_nxt;
  logic [PTR_W-1:0]                ptr;
  // Stage 0 is the issue register feeding dp_valid/dp_data; the tag leaves
  // stage PIPE_LAT in the same cycle the datapath presents its result.
  logic [PIPE_LAT:0]               vld_pipe;
  logic [PIPE_LAT:0][PTR_W-1:0]    ch_pipe;
  logic [NUM_CH-1:0]               in_flight, elig, gnt;
  logic [PTR_W-1:0]                gnt_idx;
  logic                            gnt_vld, xfer;
  logic [NUM_CH-1:0][DATA_W-1:0]   req_d, res_d;

  assign req_d    = req_data;
  assign res_data = res_d;

  // Mark every channel that still has a tag somewhere in the pipe.
  always_comb begin
    in_flight = '0;
    for (int s = 0; s <= PIPE_LAT; s++)
      if (vld_pipe[s]) in_flight[ch_pipe[s]] = 1'b1;
  end

  assign elig = req_valid & ~res_valid & ~in_flight;

  fir_sched_rr_arb #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_arb (
    .elig    (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready = (state == ST_RUN) ? gnt : '0;
  assign xfer      = (state == ST_RUN) && gnt_vld;
  assign dp_valid  = vld_pipe[0];
  assign busy      = (state != ST_IDLE) || (|res_valid);

  // Next state: DRAIN ignores en and waits only for the tag pipe to empty.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      ST_RUN:   if (!en) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(|vld_pipe)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register and round-robin pointer (advances past each grant).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer)
        ptr <= (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Issue register and tag shift; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      ch_pipe  <= '0;
      dp_data  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LAT-1:0], xfer};
      ch_pipe  <= {ch_pipe[PIPE_LAT-1:0], gnt_idx};
      if (xfer) dp_data <= req_d[gnt_idx];
    end
  end

  // Result slots: capture on tag exit, clear on consume; data is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= '0;
      res_d     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (vld_pipe[PIPE_LAT] && ch_pipe[PIPE_LAT] == PTR_W'(i)) begin
          res_valid[i] <= 1'b1;
          res_d[i]     <= dp_result;
        end else if (res_valid[i] && res_ready[i]) begin
          res_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef FIR_SCHED_STATS_EN
  logic [NUM_CH-1:0][STAT_W-1:0] cnt;
  assign stat_grant_cnt = cnt;

  // Per-channel transfer counters, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (xfer && gnt_idx == PTR_W'(i) && cnt[i] != '1)
          cnt[i] <= cnt[i] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_comp_scheduler.sv
// Scoreboard bench for fir_comp_scheduler (NUM_CH=4, DATA_W=12, PIPE_LAT=3)
// with a datapath model returning input+1 three cycles after issue.
module tb_fir_comp_scheduler;
  import fir_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  req_valid, req_ready, res_valid, res_ready;
  logic [47:0] req_data, res_data;
  logic        dp_valid, busy;
  logic [11:0] dp_data, dp_result;
`ifdef FIR_SCHED_STATS_EN
  logic [63:0] stat_grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fir_comp_scheduler #(.NUM_CH(4), .DATA_W(12), .PIPE_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .dp_valid  (dp_valid),
    .dp_data   (dp_data),
    .dp_result (dp_result),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef FIR_SCHED_STATS_EN
    ,
    .stat_grant_cnt (stat_grant_cnt)
`endif
  );

  // Datapath model: dp_data+1 appears three cycles after the issue cycle.
  logic [11:0] dpp0 = '0, dpp1 = '0, dpp2 = '0;
  always @(posedge clk) begin
    dpp0 <= dp_data + 12'd1;
    dpp1 <= dpp0;
    dpp2 <= dpp1;
  end
  assign dp_result = dpp2;

  typedef struct {
    int          ch;
    logic [11:0] d;
  } exp_t;
  exp_t sbq[$];
  logic [3:0] prev_rv = '0;

  // Monitor: grant legality, push on transfer, pop on each new result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      prev_rv <= '0;
    end else begin
      checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != 4'b0) begin
        errors++;
        $display("FAIL grant_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      for (int i = 0; i < 4; i++)
        if (req_ready[i] && req_valid[i])
          sbq.push_back('{i, req_data[i*12 +: 12] + 12'd1});
      for (int i = 0; i < 4; i++) begin
        if (res_valid[i] && !prev_rv[i]) begin
          checks++;
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL result_stale: ch%0d data=%h with nothing expected", i, res_data[i*12 +: 12]);
          end else begin
            e = sbq.pop_front();
            if (e.ch != i || res_data[i*12 +: 12] !== e.d) begin
              errors++;
              $display("FAIL result: got ch%0d=%h expected ch%0d=%h", i, res_data[i*12 +: 12], e.ch, e.d);
            end
          end
        end
      end
      prev_rv <= res_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req_valid = '0; res_ready = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; req_valid = 4'hF; res_ready = '0; req_data = '1;
    step(); step();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0 || dp_valid !== 1'b0 || dp_data !== 12'h0 ||
        res_valid !== 4'b0 || res_data !== 48'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: rr=%b dpv=%b dpd=%h rv=%b rd=%h busy=%b expected all zero",
               req_ready, dp_valid, dp_data, res_valid, res_data, busy);
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1;
    step();
    req_valid = 4'b0100; req_data = {12'h000, 12'h123, 24'h0}; res_ready = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_grant: req_ready=%b expected 0100", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (dp_valid !== 1'b1 || dp_data !== 12'h123) begin
      errors++; $display("FAIL single_issue: dp_valid=%b dp_data=%h expected 1/123", dp_valid, dp_data);
    end
    for (int c = 2; c < 5; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (res_valid !== 4'b0 || dp_valid !== 1'b0) begin
        errors++; $display("FAIL single_early: cycle %0d res_valid=%b dp_valid=%b expected 0", c, res_valid, dp_valid);
      end
    end
    step();
    @(negedge clk);
    checks++;
    if (res_valid !== 4'b0100 || res_data[35:24] !== 12'h124) begin
      errors++; $display("FAIL single_result: res_valid=%b data=%h expected 0100/124", res_valid, res_data[35:24]);
    end
    step();
    res_ready = 4'b0101;   // bit 0 targets an empty slot and must be ignored
    @(negedge clk);
    step();
    res_ready = '0;
    @(negedge clk);
    checks++;
    if (res_valid !== 4'b0 || res_data[35:24] !== 12'h124 || res_data[11:0] !== 12'h0) begin
      errors++; $display("FAIL single_clear: res_valid=%b data=%h expected 0000/124", res_valid, res_data[35:24]);
    end
  endtask

  task automatic test_round_robin();
    int first_regrant;
    first_regrant = -1;
    do_reset();
    en = 1'b1; res_ready = 4'hF;
    req_data = {12'hFFF, 12'h300, 12'h200, 12'h100};
    step();
    req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c < 4) begin
        checks++;
        if (req_ready !== (4'b0001 << c)) begin
          errors++; $display("FAIL rr_order: cycle %0d req_ready=%b expected %b", c, req_ready, 4'b0001 << c);
        end
      end else if (req_ready[0] && first_regrant < 0) begin
        first_regrant = c;
      end
      step();
    end
    checks++;
    if (first_regrant < 6) begin
      errors++; $display("FAIL rr_regrant: ch0 regrant cycle=%0d expected >=6", first_regrant);
    end
    req_valid = '0;
    repeat (8) step();
  endtask

  task automatic test_backpressure();
    int g[4];
    logic [11:0] saved;
    for (int i = 0; i < 4; i++) g[i] = 0;
    res_ready = 4'b1101; req_valid = 4'hF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (res_valid[1] && req_ready[1]) begin
        errors++; $display("FAIL bp_regrant: cycle %0d ch1 granted with full slot", c);
      end
      for (int i = 0; i < 4; i++) if (req_ready[i]) g[i]++;
      step();
    end
    checks++;
    if (g[1] != 1 || g[0] < 3 || g[2] < 3 || g[3] < 3 || res_valid[1] !== 1'b1) begin
      errors++; $display("FAIL bp_counts: grants=%0d/%0d/%0d/%0d rv1=%b expected ch1=1 others>=3 rv1=1",
                         g[0], g[1], g[2], g[3], res_valid[1]);
    end
    req_valid = '0;
    repeat (6) step();
    @(negedge clk);
    saved = res_data[23:12];
    step();
    res_ready = 4'hF;
    @(negedge clk);
    checks++;
    if (res_valid[1] !== 1'b1) begin
      errors++; $display("FAIL bp_hold: res_valid[1]=%b expected 1", res_valid[1]);
    end
    step();
    @(negedge clk);
    checks++;
    if (res_valid[1] !== 1'b0 || res_data[23:12] !== saved) begin
      errors++; $display("FAIL bp_clear: res_valid[1]=%b data=%h expected 0/%h", res_valid[1], res_data[23:12], saved);
    end
  endtask

  task automatic test_drain();
    int idle_at;
    idle_at = -1;
    do_reset();
    en = 1'b1; res_ready = '0;
    req_data = {12'h444, 12'h333, 12'h222, 12'h111};
    step();
    req_valid = 4'b0111;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    en = 1'b0;                 // RUN ends after cycle 2
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL drain_grant3: req_ready=%b expected 0100", req_ready);
    end
    step();
    req_valid = 4'hF;
    for (int c = 3; c < 23 && idle_at < 0; c++) begin
      if (c == 4) en = 1'b1;
      if (c == 5) en = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0) begin
        errors++; $display("FAIL drain_noready: cycle %0d req_ready=%b expected 0", c, req_ready);
      end
      if (c == 5) begin
        checks++;
        if (dut.state !== ST_DRAIN) begin
          errors++; $display("FAIL drain_en: state=%0d expected DRAIN", dut.state);
        end
      end
      if (dut.state === ST_IDLE) idle_at = c;
      else step();
    end
    checks++;
    if (idle_at < 0 || res_valid !== 4'b0111 || busy !== 1'b1) begin
      errors++; $display("FAIL drain_idle: idle_at=%0d res_valid=%b busy=%b expected IDLE/0111/1", idle_at, res_valid, busy);
    end
    req_valid = '0;
    step();
    res_ready = 4'hF;
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res_valid !== 4'b0) begin
      errors++; $display("FAIL drain_busy: busy=%b res_valid=%b expected 0", busy, res_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; res_ready = 4'hF;
    req_data = {12'h0, 12'h0, 12'h0AA, 12'h055};
    step();
    req_valid = 4'b0011;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rmid_grant: req_ready=%b expected 0001", req_ready);
    end
    step();
    step();
    rst = 1'b1; en = 1'b0; req_valid = '0;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (res_valid !== 4'b0 || dp_valid !== 1'b0 || dut.state !== ST_IDLE) begin
      errors++; $display("FAIL rmid_state: res_valid=%b dp_valid=%b state=%0d expected 0/0/IDLE", res_valid, dp_valid, dut.state);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge clk);
      checks++;
      if (res_valid !== 4'b0) begin
        errors++; $display("FAIL rmid_stale: cycle %0d res_valid=%b expected 0", c, res_valid);
      end
    end
  endtask

`ifdef FIR_SCHED_STATS_EN
  task automatic test_stats();
    int n;
    n = 0;
    do_reset();
    en = 1'b1; res_ready = 4'hF; req_data = {12'h7FF, 36'h0};
    step();
    req_valid = 4'b1000;
    for (int c = 0; c < 80 && n < 5; c++) begin
      @(negedge clk);
      if (req_ready[3]) n++;
      step();
    end
    req_valid = '0;
    repeat (8) step();
    @(negedge clk);
    checks++;
    if (stat_grant_cnt !== {16'd5, 48'h0}) begin
      errors++; $display("FAIL stats: cnt=%h expected 0005_0000_0000_0000", stat_grant_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_reset_mid();
`ifdef FIR_SCHED_STATS_EN
    test_stats();
`endif
    en = 1'b0; req_valid = '0; res_ready = 4'hF;
    repeat (10) step();
    @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL sb_empty: %0d results never delivered, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
